// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches 1- or 2-byte
// instructions from a 1-cycle-latency memory and hands them to the decoder.
module instr_fetch_unit #(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter logic [1:0] LONG_PREFIX = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  iAddr,
  output logic        FETCH,
  input  logic [7:0]  instr,
  output logic [15:0] ir,
  output logic        ir_len,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        jmp_en,
  input  logic [7:0]  jmp_addr,
  output logic [7:0]  pc
);

  typedef enum logic [2:0] {
    S_F1  = 3'd0,
    S_L1  = 3'd1,
    S_F2  = 3'd2,
    S_L2  = 3'd3,
    S_OUT = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  pc_r;
  logic [7:0]  op_r;
  logic [7:0]  operand_r;
  logic        ir_len_r;
  logic [7:0]  ir_pc_r;
  logic        fetch_s;

  // Next-state decode and memory read strobe.
  always_comb begin
    state_next_s = state_r;
    fetch_s      = 1'b0;
    case (state_r)
      S_F1: begin
        if (run) begin
          fetch_s      = 1'b1;
          state_next_s = S_L1;
        end else begin
          fetch_s      = 1'b0;
          state_next_s = S_F1;
        end
      end
      S_L1: begin
        if (instr[7:6] == LONG_PREFIX) begin
          state_next_s = S_F2;
        end else begin
          state_next_s = S_OUT;
        end
      end
      S_F2: begin
        fetch_s      = 1'b1;
        state_next_s = S_L2;
      end
      S_L2: begin
        state_next_s = S_OUT;
      end
      S_OUT: begin
        if (ir_ready) begin
          state_next_s = S_F1;
        end else begin
          state_next_s = S_OUT;
        end
      end
      default: begin
        state_next_s = S_F1;
      end
    endcase
  end

  // State, program counter and instruction assembly registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_F1;
      pc_r      <= PC_RESET;
      op_r      <= 8'h00;
      operand_r <= 8'h00;
      ir_len_r  <= 1'b0;
      ir_pc_r   <= 8'h00;
    end else if (jmp_en) begin
      // Redirect drops any partial instruction; data from a fetch issued now is never loaded.
      state_r <= S_F1;
      pc_r    <= jmp_addr;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        S_L1: begin
          op_r    <= instr;
          ir_pc_r <= pc_r;
          pc_r    <= pc_r + 8'd1;
          if (instr[7:6] == LONG_PREFIX) begin
            ir_len_r <= 1'b1;
          end else begin
            ir_len_r  <= 1'b0;
            operand_r <= 8'h00;
          end
        end
        S_L2: begin
          operand_r <= instr;
          pc_r      <= pc_r + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign iAddr    = pc_r;
  assign pc       = pc_r;
  assign FETCH    = fetch_s;
  assign ir       = {op_r, operand_r};
  assign ir_len   = ir_len_r;
  assign ir_pc    = ir_pc_r;
  assign ir_valid = (state_r == S_OUT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model, scoreboard queue of
// expected instructions and a monitor that checks each accepted word.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  iAddr;
  logic        FETCH;
  logic [7:0]  instr;
  logic [15:0] ir;
  logic        ir_len;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic [7:0]  pc;

  logic [7:0]  mem [256];
  logic [24:0] exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .run(run), .iAddr(iAddr), .FETCH(FETCH),
    .instr(instr), .ir(ir), .ir_len(ir_len), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .jmp_en(jmp_en),
    .jmp_addr(jmp_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  always @(posedge clk) begin
    if (FETCH) instr <= mem[iAddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", {7'd0, ir, ir_len, ir_pc}, 32'hFFFF_FFFF);
      end else begin
        chk("accepted_ir", {7'd0, ir, ir_len, ir_pc}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  // Waits for ir_valid, returning the number of cycles waited.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (ir_valid !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles = cycles + 1;
    end
    if (ir_valid !== 1'b1) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept(input logic [15:0] e_ir, input logic e_len, input logic [7:0] e_pc);
    exp_q.push_back({e_ir, e_len, e_pc});
    @(posedge clk); #1 ir_ready = 1'b1;
    @(posedge clk); #1 ir_ready = 1'b0;
  endtask

  task automatic jump(input logic [7:0] addr);
    @(posedge clk); #1 jmp_en = 1'b1; jmp_addr = addr;
    @(posedge clk); #1 jmp_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h13;
    mem[8'h03] = 8'hC2; mem[8'h04] = 8'h55; mem[8'h05] = 8'h20;
    mem[8'h06] = 8'hD0; mem[8'h07] = 8'h34;
    mem[8'h10] = 8'h05; mem[8'hFF] = 8'hC1;
    rst = 1'b1; run = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // run=0 after reset: nothing happens
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_fetch", {31'd0, FETCH}, 32'd0);
      chk("idle_valid", {31'd0, ir_valid}, 32'd0);
      chk("idle_pc", {24'd0, pc}, 32'h00);
    end
    chk("reset_ir", {16'd0, ir}, 32'h0000);

    // 1-byte instruction at 0
    @(posedge clk); #1 run = 1'b1;
    @(negedge clk);
    chk("f1_fetch", {31'd0, FETCH}, 32'd1);
    chk("f1_addr", {24'd0, iAddr}, 32'h00);
    wait_valid(n);
    chk("short_latency", n, 32'd2);
    run = 1'b0;
    chk("short_pc", {24'd0, pc}, 32'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ir_valid}, 32'd1);
      chk("hold_ir", {16'd0, ir}, 32'h1300);
      chk("hold_fetch", {31'd0, FETCH}, 32'd0);
      chk("hold_pc", {24'd0, pc}, 32'h01);
    end
    accept(16'h1300, 1'b0, 8'h00);
    @(negedge clk);
    chk("after_accept_valid", {31'd0, ir_valid}, 32'd0);

    // 2-byte instruction at 6
    run = 1'b1;
    jump(8'h06);
    @(negedge clk);
    chk("long_f1", {23'd0, FETCH, iAddr}, {23'd0, 1'b1, 8'h06});
    @(negedge clk);
    chk("long_l1_fetch", {31'd0, FETCH}, 32'd0);
    @(negedge clk);
    chk("long_f2", {23'd0, FETCH, iAddr}, {23'd0, 1'b1, 8'h07});
    wait_valid(n);
    chk("long_latency_tail", n, 32'd2);
    run = 1'b0;
    chk("long_pc", {24'd0, pc}, 32'h08);
    accept(16'hD034, 1'b1, 8'h06);

    // redirect during S_L2 drops the partial 2-byte instruction at 3
    run = 1'b1;
    jump(8'h03);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("redir_f2_addr", {24'd0, iAddr}, 32'h04);
    @(posedge clk); #1 jmp_en = 1'b1; jmp_addr = 8'h05;
    @(posedge clk); #1 jmp_en = 1'b0;
    @(negedge clk);
    chk("redir_f1", {23'd0, FETCH, iAddr}, {23'd0, 1'b1, 8'h05});
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    wait_valid(n);
    chk("redir_latency", n, 32'd2);
    run = 1'b0;
    chk("redir_pc", {24'd0, pc}, 32'h06);
    accept(16'h2000, 1'b0, 8'h05);

    // PC wrap: opcode at FF, operand at 00
    mem[8'h00] = 8'h7E;
    run = 1'b1;
    jump(8'hFF);
    @(negedge clk);
    chk("wrap_f1_addr", {24'd0, iAddr}, 32'hFF);
    wait_valid(n);
    chk("wrap_latency", n, 32'd4);
    run = 1'b0;
    chk("wrap_pc", {24'd0, pc}, 32'h01);
    accept(16'hC17E, 1'b1, 8'hFF);

    // jmp_en together with ir_ready in S_OUT: consumed and redirected
    run = 1'b1;
    jump(8'h10);
    @(negedge clk);
    wait_valid(n);
    run = 1'b0;
    exp_q.push_back({16'h0500, 1'b0, 8'h10});
    @(posedge clk); #1 ir_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h20;
    @(posedge clk); #1 ir_ready = 1'b0; jmp_en = 1'b0;
    @(negedge clk);
    chk("jmp_ready_pc", {24'd0, pc}, 32'h20);
    chk("jmp_ready_valid", {31'd0, ir_valid}, 32'd0);

    // reset during S_L1
    run = 1'b1;
    jump(8'h06);
    @(posedge clk); #1 rst = 1'b1; run = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_ir", {16'd0, ir}, 32'h0000);
    chk("rst_len_pc", {23'd0, ir_len, ir_pc}, 32'd0);
    chk("rst_valid_fetch", {30'd0, ir_valid, FETCH}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sits directly upstream of the instruction memory and feeds the decoder/control unit.
- Owns the 8-bit program counter and drives iAddr and FETCH.
- Absorbs the memory's 1-cycle registered read latency and assembles 1- or 2-byte instructions into a 16-bit word.
- Hands each word to the decoder over a valid/ready handshake and supports redirects (jumps) from the control unit.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- LONG_PREFIX, 2'b11, value of opcode bits [7:6] that marks a 2-byte instruction (opcode + operand byte).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; 0 stalls before the next opcode fetch.
- iAddr  output  8  instruction address to memory.
- FETCH  output  1  memory read strobe; memory registers instr on the same edge.
- instr  input  8  memory read data, valid the cycle after FETCH.
- ir  output  16  {opcode, operand}; operand is 8'h00 for 1-byte instructions.
- ir_len  output  1  0 = 1-byte instruction, 1 = 2-byte instruction.
- ir_pc  output  8  address of the opcode byte of ir.
- ir_valid  output  1  ir/ir_len/ir_pc are valid.
- ir_ready  input  1  decoder accepts ir this cycle when ir_valid=1.
- jmp_en  input  1  redirect request.
- jmp_addr  input  8  redirect target.
- pc  output  8  current program counter, the next byte to fetch.

Behaviour:
- Reset, synchronous on a clk edge with rst=1:
  - pc=PC_RESET; state=S_F1.
  - ir=0, ir_len=0, ir_pc=0, ir_valid=0, FETCH=0.
  - rst has priority over jmp_en and run.
- FSM states: S_F1, S_L1, S_F2, S_L2, S_OUT.
- S_F1:
  - iAddr=pc.
  - If run=1: FETCH=1, next state S_L1.
  - If run=0: FETCH=0, stay in S_F1.
- S_L1:
  - FETCH=0; capture instr into op_reg; pc<=pc+1.
  - If instr[7:6]==LONG_PREFIX, next state S_F2; else S_OUT with operand=0.
- S_F2:
  - FETCH=1, iAddr=pc, next state S_L2. run is ignored once an instruction has started.
- S_L2:
  - FETCH=0; capture instr into operand; pc<=pc+1; next state S_OUT.
- S_OUT:
  - ir_valid=1; ir/ir_len/ir_pc are held stable.
  - If ir_ready=1: next state S_F1 (ir_valid is 0 the following cycle).
  - If ir_ready=0: stay in S_OUT.
- FETCH is combinational from state and run; iAddr equals pc in every state.
- Latency from entering S_F1 with run=1 to ir_valid=1:
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 4 cycles.
  - Peak throughput: one 1-byte instruction per 3 cycles.
- PC arithmetic is 8-bit modulo; 8'hFF+1 wraps to 8'h00.
  - A 2-byte instruction whose opcode is at 8'hFF takes its operand from 8'h00.
- Redirect: jmp_en=1 in any state, rst=0:
  - pc<=jmp_addr; state<=S_F1; ir_valid<=0.
  - Any partially assembled or pending instruction is discarded.
  - Read data arriving the next cycle from a FETCH issued in the jmp_en cycle is ignored.
  - If jmp_en and ir_ready are both 1 in S_OUT, the handshake completes (the instruction is consumed) and the redirect also applies.
- ir_valid never depends combinationally on ir_ready.

Test Plan:
- Reset, then run=1 with memory[0]=8'h13: ir_valid rises 2 cycles after the first FETCH with ir=16'h1300, ir_len=0, ir_pc=0; pc=1.
- Memory[6]=8'hD0, memory[7]=8'h34, pc=6: FETCH pulses at iAddr=6 and then 7; ir=16'hD034, ir_len=1, ir_pc=6; pc=8.
- Hold ir_ready=0 for 5 cycles in S_OUT: ir_valid stays 1, ir unchanged, no FETCH pulses, pc unchanged; release → exactly one acceptance.
- Assert jmp_en with jmp_addr=8'h05 during S_L2: partial instruction is dropped, next FETCH is at iAddr=5, next ir_pc=5.
- pc=8'hFF with opcode 8'hC1 at 8'hFF and 8'h7E at 8'h00: ir=16'hC17E, pc wraps to 8'h01.
- run=0 from reset for 4 cycles: FETCH=0 and ir_valid=0 throughout. Then rst=1 during S_L1: all outputs return to reset values next cycle and pc=PC_RESET.
